// File: rtl/scratchpad_mem_pkg.sv
// Shared encodings and store-lane helpers for the scratchpad memory responder.
package scratchpad_mem_pkg;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} host_state_e;

  // An all-zero mask marks an unsupported store type.
  function automatic logic [3:0] store_mask(input logic [2:0] typ, input logic [1:0] addr_lo);
    case (typ)
      MT_B:    store_mask = 4'b0001 << addr_lo;
      MT_H:    store_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      MT_W:    store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] typ, input logic [31:0] data);
    case (typ)
      MT_B:    store_data = {4{data[7:0]}};
      MT_H:    store_data = {2{data[15:0]}};
      default: store_data = data;
    endcase
  endfunction

endpackage

// File: rtl/scratchpad_mem_responder_if.sv
// Core data-memory port and host HTIF memory channel; master drives requests.
interface scratchpad_mem_responder_if;
  logic        core_req_val;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_data;
  logic        core_req_fcn;
  logic [2:0]  core_req_typ;
  logic [31:0] core_resp_data;

  logic        htif_req_valid;
  logic        htif_req_ready;
  logic        htif_req_rw;
  logic [63:0] htif_req_addr;
  logic [63:0] htif_req_data;
  logic        htif_rep_valid;
  logic [63:0] htif_rep_bits;

  modport master (
    output core_req_val, core_req_addr, core_req_data, core_req_fcn, core_req_typ,
    input  core_resp_data,
    output htif_req_valid, htif_req_rw, htif_req_addr, htif_req_data,
    input  htif_req_ready, htif_rep_valid, htif_rep_bits
  );

  modport slave (
    input  core_req_val, core_req_addr, core_req_data, core_req_fcn, core_req_typ,
    output core_resp_data,
    input  htif_req_valid, htif_req_rw, htif_req_addr, htif_req_data,
    output htif_req_ready, htif_rep_valid, htif_rep_bits
  );
endinterface

// File: rtl/scratchpad_mem_responder_mem_load_align.sv
// Picks the addressed byte/half/word out of a memory word and extends it.
module mem_load_align
  import scratchpad_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  typ,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (typ)
      MT_B:    data = {{24{byte_sel[7]}}, byte_sel};
      MT_BU:   data = {24'h0, byte_sel};
      MT_H:    data = {{16{half_sel[15]}}, half_sel};
      MT_HU:   data = {16'h0, half_sel};
      MT_W:    data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/scratchpad_mem_responder.sv
// Word-organised scratchpad: combinational core loads, byte-enabled core stores,
// and a host doubleword engine that moves one word per cycle behind core stores.
module scratchpad_mem_responder
  import scratchpad_mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 4096,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input logic clk,
  input logic reset,
  scratchpad_mem_responder_if.slave bus
);

  host_state_e       state_q, state_d;
  logic              rw_q, rw_d;
  logic [IDX_W-2:0]  dw_idx_q, dw_idx_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  core_idx, host_idx, wr_idx;
  logic [3:0]        core_mask, wr_mask;
  logic [31:0]       wr_data, host_rd_word, load_data;
  logic              core_store, wr_en;
  logic              req_ready, rep_valid;
  logic [63:0]       rep_bits;
  logic              unused_addr_bits;

  assign core_idx     = bus.core_req_addr[IDX_W+1:2];
  assign core_mask    = store_mask(bus.core_req_typ, bus.core_req_addr[1:0]);
  assign core_store   = bus.core_req_val && (bus.core_req_fcn == M_XWR) && (core_mask != 4'b0);
  assign host_idx     = {dw_idx_q, state_q == HI};
  assign host_rd_word = mem_q[host_idx];

  assign unused_addr_bits = ^{bus.core_req_addr[31:IDX_W+2], bus.htif_req_addr[63:IDX_W+2],
                              bus.htif_req_addr[2:0]};

  mem_load_align u_load_align (
    .word    (mem_q[core_idx]),
    .addr_lo (bus.core_req_addr[1:0]),
    .typ     (bus.core_req_typ),
    .data    (load_data)
  );

  assign bus.core_resp_data = (bus.core_req_val && bus.core_req_fcn == M_XRD) ? load_data : 32'h0;
  assign bus.htif_req_ready = req_ready;
  assign bus.htif_rep_valid = rep_valid;
  assign bus.htif_rep_bits  = rep_bits;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    rw_d      = rw_q;
    dw_idx_d  = dw_idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rep_valid = 1'b0;
    rep_bits  = 64'h0;
    wr_en     = core_store;
    wr_idx    = core_idx;
    wr_mask   = core_mask;
    wr_data   = store_data(bus.core_req_typ, bus.core_req_data);

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.htif_req_valid) begin
          rw_d     = bus.htif_req_rw;
          dw_idx_d = bus.htif_req_addr[IDX_W+1:3];
          wdata_d  = bus.htif_req_data;
          state_d  = LO;
        end
      end
      LO, HI: begin
        // Host writes share the single write port and lose it to any core store.
        if (!rw_q || !core_store) begin
          state_d = (state_q == LO) ? HI : RESP;
          if (rw_q) begin
            wr_en   = !reset;
            wr_idx  = host_idx;
            wr_mask = 4'b1111;
            wr_data = (state_q == HI) ? wdata_q[63:32] : wdata_q[31:0];
          end else if (state_q == LO) begin
            rdata_d[31:0] = host_rd_word;
          end else begin
            rdata_d[63:32] = host_rd_word;
          end
        end
      end
      RESP: begin
        rep_valid = 1'b1;
        rep_bits  = rw_q ? 64'h0 : rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rw_q     <= 1'b0;
      dw_idx_q <= '0;
      wdata_q  <= 64'h0;
      rdata_q  <= 64'h0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      dw_idx_q <= dw_idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_scratchpad_mem_responder.sv
// Directed and randomized bench for scratchpad_mem_responder against a byte-level memory model.
module tb_scratchpad_mem_responder;
  import scratchpad_mem_pkg::*;

  localparam int MEMB = 4 * 4096;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  scratchpad_mem_responder_if bus ();

  scratchpad_mem_responder #(.DEPTH_WORDS(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed reference memory; addresses wrap modulo the scratchpad size.
  logic [7:0] mb [int];

  function automatic int ba(input logic [31:0] a);
    return int'(a & 32'(MEMB - 1));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] typ);
    int b, hb, wb;
    logic [7:0]  by;
    logic [15:0] h;
    b  = ba(a);
    hb = b - (b % 2);
    wb = b - (b % 4);
    by = mb[b];
    h  = {mb[hb+1], mb[hb]};
    case (typ)
      MT_B:    return {{24{by[7]}}, by};
      MT_BU:   return {24'h0, by};
      MT_H:    return {{16{h[15]}}, h};
      MT_HU:   return {16'h0, h};
      MT_W:    return {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] typ);
    int b, n;
    b = ba(a);
    case (typ)
      MT_B:    n = 1;
      MT_H:    n = 2;
      MT_W:    n = 4;
      default: n = 0;
    endcase
    if (n != 0) b = b - (b % n);
    for (int i = 0; i < n; i++) mb[b+i] = d[8*i +: 8];
  endtask

  task automatic m_host_write(input logic [63:0] a, input logic [63:0] d, input int nbytes);
    int b;
    b = ba(a[31:0]);
    b = b - (b % 8);
    for (int i = 0; i < nbytes; i++) mb[b+i] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] m_host_read(input logic [63:0] a);
    int b;
    logic [63:0] r;
    b = ba(a[31:0]);
    b = b - (b % 8);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mb[b+i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_reply(input int base, output logic [63:0] bits, output int lat);
    logic found;
    found = 1'b0;
    lat   = 0;
    bits  = 64'h0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (bus.htif_rep_valid === 1'b1) begin
        found = 1'b1;
        lat   = base + i;
        bits  = bus.htif_rep_bits;
      end else begin
        check("ready_low_busy", 64'(bus.htif_req_ready), 64'd0);
      end
      @(posedge clk); #1;
    end
    check("reply_seen", 64'(found), 64'd1);
    @(negedge clk);
    check("rep_single_pulse", 64'(bus.htif_rep_valid), 64'd0);
    check("ready_back", 64'(bus.htif_req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic host_op(input logic rw, input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] bits);
    int lat;
    bus.htif_req_valid = 1'b1;
    bus.htif_req_rw    = rw;
    bus.htif_req_addr  = a;
    bus.htif_req_data  = d;
    @(negedge clk);
    check("ready_idle", 64'(bus.htif_req_ready), 64'd1);
    @(posedge clk); #1;
    bus.htif_req_valid = 1'b0;
    wait_reply(0, bits, lat);
    check("host_latency", 64'(lat), 64'd3);
    if (rw) begin
      check("host_write_bits", bits, 64'h0);
      m_host_write(a, d, 8);
    end
  endtask

  task automatic core_load(input logic [31:0] a, input logic [2:0] typ,
                           input logic [31:0] exp, input string tag);
    bus.core_req_val  = 1'b1;
    bus.core_req_fcn  = M_XRD;
    bus.core_req_addr = a;
    bus.core_req_typ  = typ;
    bus.core_req_data = $urandom;
    @(negedge clk);
    check(tag, 64'(bus.core_resp_data), 64'(exp));
    @(posedge clk); #1;
    bus.core_req_val = 1'b0;
  endtask

  task automatic core_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] typ);
    bus.core_req_val  = 1'b1;
    bus.core_req_fcn  = M_XWR;
    bus.core_req_addr = a;
    bus.core_req_typ  = typ;
    bus.core_req_data = d;
    @(negedge clk);
    check("store_resp_zero", 64'(bus.core_resp_data), 64'd0);
    @(posedge clk); #1;
    bus.core_req_val = 1'b0;
    m_store(a, d, typ);
  endtask

  initial begin
    logic [63:0] bits, hd, old_hi;
    logic [31:0] a;
    logic [2:0]  typ;
    int lat;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.core_req_val   = 1'b0;
    bus.core_req_addr  = 32'h0;
    bus.core_req_data  = 32'h0;
    bus.core_req_fcn   = M_XRD;
    bus.core_req_typ   = MT_W;
    bus.htif_req_valid = 1'b0;
    bus.htif_req_rw    = 1'b0;
    bus.htif_req_addr  = 64'h0;
    bus.htif_req_data  = 64'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 64'(bus.htif_req_ready), 64'd1);
    check("reset_rep_valid", 64'(bus.htif_rep_valid), 64'd0);
    check("reset_rep_bits", bus.htif_rep_bits, 64'h0);
    check("idle_resp_zero", 64'(bus.core_resp_data), 64'd0);
    @(posedge clk); #1;

    // Give the low 256 bytes known contents.
    for (int i = 0; i < 32; i++) host_op(1'b1, 64'(i * 8), {$urandom, $urandom}, bits);

    host_op(1'b1, 64'h10, 64'h1122334455667788, bits);
    host_op(1'b0, 64'h10, 64'h0, bits);
    check("host_read_0x10", bits, 64'h1122334455667788);

    core_load(32'h10, MT_W,  32'h55667788, "ld_w_0x10");
    core_load(32'h13, MT_B,  32'h00000055, "ld_b_0x13");
    core_load(32'h16, MT_H,  32'h00001122, "ld_h_0x16");
    core_load(32'h16, MT_HU, 32'h00001122, "ld_hu_0x16");
    core_store(32'h14, 32'h00000080, MT_B);
    core_load(32'h14, MT_B,  32'hFFFFFF80, "ld_b_0x14");
    core_load(32'h14, MT_BU, 32'h00000080, "ld_bu_0x14");
    core_load(32'h14, MT_W,  32'h11223380, "ld_w_0x14");

    core_store(32'h20, 32'hFFFFFFFF, MT_W);
    core_store(32'h21, 32'h000000AB, MT_B);
    core_load(32'h20, MT_W, 32'hFFFFABFF, "sb_0x21");
    core_store(32'h22, 32'h00001234, MT_H);
    core_load(32'h20, MT_W, 32'h1234ABFF, "sh_0x22");
    core_load(32'h20, 3'd4, 32'h0, "ld_unsupported_typ");
    bus.core_req_addr = 32'h20;
    bus.core_req_typ  = MT_W;
    bus.core_req_fcn  = M_XRD;
    @(negedge clk);
    check("ld_val_low", 64'(bus.core_resp_data), 64'd0);
    @(posedge clk); #1;

    // Host write to 0x40 blocked by two back-to-back core stores to the same word.
    hd = 64'hA5A5_0044_5A5A_0040;
    bus.htif_req_valid = 1'b1;
    bus.htif_req_rw    = 1'b1;
    bus.htif_req_addr  = 64'h40;
    bus.htif_req_data  = hd;
    @(posedge clk); #1;
    bus.htif_req_valid = 1'b0;
    bus.core_req_val   = 1'b1;
    bus.core_req_fcn   = M_XWR;
    bus.core_req_typ   = MT_W;
    bus.core_req_addr  = 32'h40;
    bus.core_req_data  = 32'h1111_1111;
    @(posedge clk); #1;
    bus.core_req_data  = 32'h2222_2222;
    @(posedge clk); #1;
    bus.core_req_val   = 1'b0;
    wait_reply(2, bits, lat);
    check("blocked_latency", 64'(lat), 64'd5);
    check("blocked_bits", bits, 64'h0);
    m_host_write(64'h40, hd, 8);
    core_load(32'h40, MT_W, 32'h5A5A_0040, "blocked_final_lo");
    core_load(32'h44, MT_W, 32'hA5A5_0044, "blocked_final_hi");

    // Reset during HI of a host write: low word sticks, high word untouched, no reply.
    old_hi = 64'(m_load(32'h44, MT_W));
    bus.htif_req_valid = 1'b1;
    bus.htif_req_rw    = 1'b1;
    bus.htif_req_addr  = 64'h40;
    bus.htif_req_data  = 64'h0BAD_F00D_C0DE_0040;
    @(posedge clk); #1;
    bus.htif_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_host_write(64'h40, 64'h0BAD_F00D_C0DE_0040, 4);
    @(negedge clk);
    check("abort_ready", 64'(bus.htif_req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_reply", 64'(bus.htif_rep_valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    core_load(32'h40, MT_W, 32'hC0DE_0040, "abort_lo_written");
    core_load(32'h44, MT_W, old_hi[31:0], "abort_hi_kept");
    check("abort_hi_value", old_hi, 64'h0000_0000_A5A5_0044);

    core_store(32'h4008, 32'hDEADBEEF, MT_W);
    host_op(1'b0, 64'h8, 64'h0, bits);
    check("alias_lo", 64'(bits[31:0]), 64'hDEADBEEF);
    check("alias_full", bits, m_host_read(64'h8));

    for (int n = 0; n < 150; n++) begin
      a   = 32'($urandom_range(0, 255)) + 32'h4000 * 32'($urandom_range(0, 7));
      typ = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: core_load(a, typ, m_load(a, typ), "rand_load");
        1: core_store(a, $urandom, typ);
        2: begin
          host_op(1'b0, {32'($urandom), a}, 64'h0, bits);
          check("rand_host_read", bits, m_host_read(64'(a)));
        end
        default: host_op(1'b1, {32'($urandom), a}, {$urandom, $urandom}, bits);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
